// File: rtl/modulo_product.sv
// Montgomery-domain operand prep: m = a * 2^WIDTH mod N by WIDTH serial modular doublings.
// Optional MODPROD_INPUT_REDUCE_EN adds a one-cycle input reduction so a < 2N is accepted.
module modulo_product #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] m,
  output logic             finish,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_CALC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             finish_q, finish_d;
  logic             busy_q, busy_d;

  // Doubling and trial subtraction at WIDTH+1 bits; bit WIDTH of the difference is the borrow.
  logic [WIDTH:0] dbl;
  logic [WIDTH:0] dbl_sub;
  assign dbl     = {t_q, 1'b0};
  assign dbl_sub = dbl - {1'b0, n_q};

`ifdef MODPROD_INPUT_REDUCE_EN
  logic [WIDTH:0] red_sub;
  assign red_sub = {1'b0, t_q} - {1'b0, n_q};
`endif

  always_comb begin
    // NOTE: every _d gets a default up front so no path through the case infers a latch.
    state_d  = state_q;
    t_d      = t_q;
    n_d      = n_q;
    count_d  = count_q;
    m_d      = m_q;
    finish_d = (state_q == S_DONE);
    busy_d   = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = N;
          t_d     = a;
          count_d = '0;
`ifdef MODPROD_INPUT_REDUCE_EN
          state_d = S_REDUCE;
`else
          state_d = S_CALC;
`endif
        end
      end
`ifdef MODPROD_INPUT_REDUCE_EN
      S_REDUCE: begin
        if (!red_sub[WIDTH]) t_d = red_sub[WIDTH-1:0];
        state_d = S_CALC;
      end
`endif
      S_CALC: begin
        t_d     = dbl_sub[WIDTH] ? dbl[WIDTH-1:0] : dbl_sub[WIDTH-1:0];
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        m_d     = t_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      n_q      <= '0;
      count_q  <= '0;
      m_q      <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      n_q      <= n_d;
      count_q  <= count_d;
      m_q      <= m_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
    end
  end

  assign m      = m_q;
  assign finish = finish_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_modulo_product.sv
// Directed bench for modulo_product: an 8-bit instance for timing/handshake cases and a
// 256-bit instance driven with moduli whose 2^256 residue is known in closed form.
module tb_modulo_product;

`ifdef MODPROD_INPUT_REDUCE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT8   = 8 + 1 + EXTRA;
  localparam int LAT256 = 256 + 1 + EXTRA;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         start8 = 1'b0;
  logic [7:0]   n8 = '0, a8 = '0, m8;
  logic         finish8, busy8;

  logic         start256 = 1'b0;
  logic [255:0] n256 = '0, a256 = '0, m256;
  logic         finish256, busy256;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  modulo_product #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .N(n8), .a(a8),
    .m(m8), .finish(finish8), .busy(busy8)
  );

  modulo_product #(.WIDTH(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .N(n256), .a(a256),
    .m(m256), .finish(finish256), .busy(busy256)
  );

  // Issue one job on the 8-bit instance; lat = edges after acceptance until finish seen (-1 on timeout).
  task automatic run8(input logic [7:0] n, input logic [7:0] av, output int lat,
                      output logic [7:0] mo, output int busy_cnt);
    @(negedge clk);
    n8 = n; a8 = av; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1; busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (busy8) busy_cnt++;
      if (finish8) begin lat = i; break; end
    end
    mo = m8;
  endtask

  task automatic run256(input logic [255:0] n, input logic [255:0] av, output int lat,
                        output logic [255:0] mo);
    @(negedge clk);
    n256 = n; a256 = av; start256 = 1'b1;
    @(posedge clk); #1;
    start256 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (finish256) begin lat = i; break; end
    end
    mo = m256;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (m8 !== 8'd0 || finish8 !== 1'b0 || busy8 !== 1'b0) begin
      bad++; $display("FAIL reset8: m=%0d fin=%b busy=%b want 0/0/0", m8, finish8, busy8);
    end
    total++;
    if (m256 !== 256'd0 || finish256 !== 1'b0 || busy256 !== 1'b0) begin
      bad++; $display("FAIL reset256: m=%0h fin=%b busy=%b want 0/0/0", m256, finish256, busy256);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int lat, bc; logic [7:0] mo;
    run8(8'd13, 8'd5, lat, mo, bc);
    total++;
    if (lat !== LAT8) begin bad++; $display("FAIL basic_lat: got %0d want %0d", lat, LAT8); end
    total++;
    if (mo !== 8'd6) begin bad++; $display("FAIL basic_m: got %0d want 6", mo); end
    @(posedge clk); #1;
    total++;
    if (finish8 !== 1'b0) begin bad++; $display("FAIL basic_pulse: finish=%b want 0", finish8); end
    repeat (3) @(posedge clk); #1;
    total++;
    if (m8 !== 8'd6) begin bad++; $display("FAIL basic_hold: got %0d want 6", m8); end
  endtask

  task automatic test_boundary();
    int lat, bc; logic [7:0] mo;
    run8(8'd1, 8'd0, lat, mo, bc);
    total++;
    if (mo !== 8'd0) begin bad++; $display("FAIL n1_a0: got %0d want 0", mo); end
    run8(8'd13, 8'd12, lat, mo, bc);
    total++;
    if (mo !== 8'd4) begin bad++; $display("FAIL a_nm1: got %0d want 4", mo); end
    run8(8'd13, 8'd0, lat, mo, bc);
    total++;
    if (mo !== 8'd0) begin bad++; $display("FAIL a0: got %0d want 0", mo); end
    run8(8'd255, 8'd200, lat, mo, bc);
    total++;
    if (mo !== 8'd200) begin bad++; $display("FAIL n255: got %0d want 200", mo); end
  endtask

  task automatic test_busy();
    int lat, bc; logic [7:0] mo;
    run8(8'd13, 8'd5, lat, mo, bc);
    total++;
    if (bc !== LAT8) begin bad++; $display("FAIL busy_cycles: got %0d want %0d", bc, LAT8); end
    @(posedge clk); #1;
    total++;
    if (busy8 !== 1'b0) begin bad++; $display("FAIL busy_drop: busy=%b want 0", busy8); end
    @(negedge clk);
    n8 = 8'd13; a8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    total++;
    if (busy8 !== 1'b0) begin bad++; $display("FAIL busy_c0: busy=%b want 0", busy8); end
    repeat (LAT8 + 2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic hold_ok;
    @(negedge clk);
    n8 = 8'd13; a8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      start8 = (i == 4);
      if (i == 4) a8 = 8'd1;
      if (finish8) begin lat = i; break; end
    end
    total++;
    if (lat !== LAT8) begin bad++; $display("FAIL b2b_lat1: got %0d want %0d", lat, LAT8); end
    total++;
    if (m8 !== 8'd6) begin bad++; $display("FAIL b2b_ignored: got %0d want 6", m8); end
    // Next start goes in during the finish cycle so it lands on the following IDLE edge.
    n8 = 8'd13; a8 = 8'd1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1; hold_ok = 1'b1; bc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (finish8) begin lat = i; break; end
      if (m8 !== 8'd6) hold_ok = 1'b0;
    end
    total++;
    if (lat !== LAT8) begin bad++; $display("FAIL b2b_lat2: got %0d want %0d", lat, LAT8); end
    total++;
    if (hold_ok !== 1'b1) begin bad++; $display("FAIL b2b_hold: m changed before finish, want 6"); end
    total++;
    if (m8 !== 8'd9) begin bad++; $display("FAIL b2b_m2: got %0d want 9", m8); end
  endtask

  task automatic test_reset_mid();
    int lat, bc; logic [7:0] mo; int fin_seen;
    @(negedge clk);
    n8 = 8'd13; a8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (m8 !== 8'd0 || busy8 !== 1'b0 || finish8 !== 1'b0) begin
      bad++; $display("FAIL rst_mid: m=%0d busy=%b fin=%b want 0/0/0", m8, busy8, finish8);
    end
    @(negedge clk); rst_n = 1'b1;
    fin_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (finish8) fin_seen++;
    end
    total++;
    if (fin_seen !== 0) begin bad++; $display("FAIL rst_nofin: saw %0d pulses want 0", fin_seen); end
    run8(8'd13, 8'd5, lat, mo, bc);
    total++;
    if (mo !== 8'd6 || lat !== LAT8) begin
      bad++; $display("FAIL rst_after: m=%0d lat=%0d want 6 lat %0d", mo, lat, LAT8);
    end
  endtask

  task automatic test_reduce();
    int lat, bc; logic [7:0] mo;
`ifdef MODPROD_INPUT_REDUCE_EN
    run8(8'd13, 8'd20, lat, mo, bc);
`else
    run8(8'd13, 8'd7, lat, mo, bc);
`endif
    total++;
    if (mo !== 8'd11 || lat !== LAT8) begin
      bad++; $display("FAIL reduce: m=%0d lat=%0d want 11 lat %0d", mo, lat, LAT8);
    end
  endtask

  task automatic test_wide();
    int lat; logic [255:0] mo, n_ones, n_half, want;
    n_ones = '1;                       // 2^256 mod (2^256-1) = 1, so m = a
    n_half = {1'b1, 255'd0} + 256'd1;  // 2^256 mod (2^255+1) = N-2, so m = -2a mod N
    want = 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
    run256(n_ones, want, lat, mo);
    total++;
    if (lat !== LAT256) begin bad++; $display("FAIL wide_lat: got %0d want %0d", lat, LAT256); end
    total++;
    if (mo !== want) begin bad++; $display("FAIL wide_ones: got %0h want %0h", mo, want); end
    run256(n_ones, n_ones - 256'd1, lat, mo);
    total++;
    if (mo !== n_ones - 256'd1) begin bad++; $display("FAIL wide_nm1: got %0h want %0h", mo, n_ones - 256'd1); end
    run256(n_half, 256'd1, lat, mo);
    want = {1'b0, {255{1'b1}}};
    total++;
    if (mo !== want) begin bad++; $display("FAIL wide_half1: got %0h want %0h", mo, want); end
    run256(n_half, 256'd3, lat, mo);
    want = {1'b1, 255'd0} - 256'd5;
    total++;
    if (mo !== want) begin bad++; $display("FAIL wide_half3: got %0h want %0h", mo, want); end
    run256(n_half, n_half - 256'd1, lat, mo);
    total++;
    if (mo !== 256'd2) begin bad++; $display("FAIL wide_halfnm1: got %0h want 2", mo); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    test_reduce();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
